ram_arbiter: RTL

Two-requester arbiter and read-return router for the single-port stack/data RAM. It sits between the RAM and its users: port A is the stack-machine core, port B is the loader/debug master. Each cycle at most one request is issued to the RAM, and read data is steered back to the port that issued the read. Arbitration is round-robin, with a lock that gives port A atomic read-read-write sequences for binary stack ops.

---
 rtl/ram_arb_pkg.sv | 29 ++
 rtl/ram_arbiter_if.sv | 37 +++
 rtl/rd_tag_pipe.sv | 30 +++
 rtl/ram_arbiter.sv | 110 +++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and limits for the two-port stack/data RAM arbiter.
package ram_arb_pkg;

    localparam int unsigned MEM_ADDR_W = 16;
    localparam int unsigned MEM_DATA_W = 16;
    localparam int unsigned RD_LAT_MIN = 1;
    localparam int unsigned RD_LAT_MAX = 4;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

    typedef struct packed {
        logic                  we;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
    } mem_req_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } rd_tag_t;

    function automatic logic lat_ok(input int unsigned lat);
        return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side bundle for both arbiter ports: A (core, with lock) and B (loader/debug).
interface ram_arbiter_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
);
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_lock;
    logic              a_gnt;
    logic              a_rvalid;
    logic [DATA_W-1:0] a_rdata;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_gnt;
    logic              b_rvalid;
    logic [DATA_W-1:0] b_rdata;

    modport master (
        output a_req, a_we, a_addr, a_wdata, a_lock,
        output b_req, b_we, b_addr, b_wdata,
        input  a_gnt, a_rvalid, a_rdata,
        input  b_gnt, b_rvalid, b_rdata
    );

    modport slave (
        input  a_req, a_we, a_addr, a_wdata, a_lock,
        input  b_req, b_we, b_addr, b_wdata,
        output a_gnt, a_rvalid, a_rdata,
        output b_gnt, b_rvalid, b_rdata
    );

endinterface

// File: rtl/rd_tag_pipe.sv
// Shift register carrying read ownership tags alongside the RAM read latency.
module rd_tag_pipe
    import ram_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 3
) (
    input  logic    clock,
    input  logic    clear,
    input  rd_tag_t push_tag,
    output rd_tag_t exit_tag
);

    rd_tag_t stage [DEPTH];

    always_ff @(posedge clock) begin
        if (clear) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= push_tag;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign exit_tag = stage[DEPTH-1];

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter for the single-port RAM with an A-side lock and in-order read-return steering.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned DATA_W       = 16
) (
    input  logic              clock,
    input  logic              reset,
    ram_arbiter_if.slave      bus,
    output logic [ADDR_W-1:0] address_ram,
    output logic [DATA_W-1:0] data_ram,
    output logic              wren_ram,
    input  logic [DATA_W-1:0] q_ram
);

    localparam int unsigned TAG_DEPTH = READ_LATENCY + 1;

    if (!lat_ok(READ_LATENCY)) begin : g_bad_latency
        $error("ram_arbiter: READ_LATENCY outside supported range");
    end
    if ((ADDR_W != MEM_ADDR_W) || (DATA_W != MEM_DATA_W)) begin : g_bad_width
        $error("ram_arbiter: ADDR_W/DATA_W must match the mem_req_t payload");
    end

    req_id_t           last_gnt;
    logic              lock_held_c;
    logic              a_gnt_c;
    logic              b_gnt_c;
    logic              gnt_any_c;
    mem_req_t          sel_req_c;
    rd_tag_t           push_tag_c;
    rd_tag_t           exit_tag;
    logic              a_rvalid_q;
    logic              b_rvalid_q;
    logic [DATA_W-1:0] a_rdata_q;
    logic [DATA_W-1:0] b_rdata_q;

    // Grant: lock keeps B out after an A grant; otherwise ties go to whoever was not served last.
    always_comb begin
        lock_held_c = bus.a_lock && (last_gnt == REQ_A);
        a_gnt_c     = !reset && bus.a_req &&
                      (!bus.b_req || (last_gnt == REQ_B) || lock_held_c);
        b_gnt_c     = !reset && bus.b_req && !lock_held_c &&
                      (!bus.a_req || (last_gnt == REQ_A));
        gnt_any_c   = a_gnt_c || b_gnt_c;
    end

    always_comb begin
        sel_req_c = '0;
        if (b_gnt_c) begin
            sel_req_c.we    = bus.b_we;
            sel_req_c.addr  = MEM_ADDR_W'(bus.b_addr);
            sel_req_c.wdata = MEM_DATA_W'(bus.b_wdata);
        end else begin
            sel_req_c.we    = bus.a_we;
            sel_req_c.addr  = MEM_ADDR_W'(bus.a_addr);
            sel_req_c.wdata = MEM_DATA_W'(bus.a_wdata);
        end
        push_tag_c.valid = gnt_any_c && !sel_req_c.we;
        push_tag_c.id    = b_gnt_c ? REQ_B : REQ_A;
    end

    rd_tag_pipe #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_pipe (
        .clock    (clock),
        .clear    (reset),
        .push_tag (push_tag_c),
        .exit_tag (exit_tag)
    );

    // RAM request registers and read-return capture at the tag pipe exit.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_gnt    <= REQ_B;
            address_ram <= '0;
            data_ram    <= '0;
            wren_ram    <= 1'b0;
            a_rvalid_q  <= 1'b0;
            b_rvalid_q  <= 1'b0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
        end else begin
            wren_ram <= gnt_any_c && sel_req_c.we;
            if (gnt_any_c) begin
                address_ram <= ADDR_W'(sel_req_c.addr);
                data_ram    <= DATA_W'(sel_req_c.wdata);
                last_gnt    <= b_gnt_c ? REQ_B : REQ_A;
            end
            a_rvalid_q <= exit_tag.valid && (exit_tag.id == REQ_A);
            b_rvalid_q <= exit_tag.valid && (exit_tag.id == REQ_B);
            if (exit_tag.valid && (exit_tag.id == REQ_A)) begin
                a_rdata_q <= q_ram;
            end
            if (exit_tag.valid && (exit_tag.id == REQ_B)) begin
                b_rdata_q <= q_ram;
            end
        end
    end

    assign bus.a_gnt    = a_gnt_c;
    assign bus.b_gnt    = b_gnt_c;
    assign bus.a_rvalid = a_rvalid_q;
    assign bus.b_rvalid = b_rvalid_q;
    assign bus.a_rdata  = a_rdata_q;
    assign bus.b_rdata  = b_rdata_q;

endmodule
